// File: rtl/led_pkg.sv
// led_fader shared definitions.
// Board clock, channel count and level type defaults.
package led_pkg;

    localparam int FREQUENCY = 27_000_000;
    localparam int N_LEDS    = 8;
    localparam int PWM_BITS  = 8;
    localparam int FADE_DIV  = 105_469;
    localparam int STEP      = 8;

    typedef logic [PWM_BITS-1:0] level_t;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: saturating ramp of the level toward its target,
// PWM compare against the shared counter, registered LED drive.
module led_pwm_channel #(
    parameter int PWM_BITS = led_pkg::PWM_BITS,
    parameter int STEP     = led_pkg::STEP
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                tick,
    input  logic                on,
    input  logic [PWM_BITS-1:0] max_level,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic                busy
);

    localparam logic [PWM_BITS:0] STEP_W = (PWM_BITS+1)'(STEP);

    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS-1:0] level_nxt;
    logic [PWM_BITS:0]   up_sum;
    logic [PWM_BITS:0]   down_gap;

    // Target follows the live pattern bit and ceiling.
    always_comb begin
        target = on ? max_level : '0;
    end

    // One step toward target, clamped so it never overshoots.
    always_comb begin
        up_sum    = {1'b0, level} + STEP_W;
        down_gap  = {1'b0, level} - {1'b0, target};
        level_nxt = level;
        if (level < target) begin
            if (up_sum >= {1'b0, target})
                level_nxt = target;
            else
                level_nxt = up_sum[PWM_BITS-1:0];
        end else if (level > target) begin
            if (down_gap <= STEP_W)
                level_nxt = target;
            else
                level_nxt = level - STEP_W[PWM_BITS-1:0];
        end
    end

    // Level register: cleared while disabled, stepped on fade ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            level <= '0;
        else if (!en)
            level <= '0;
        else if (tick)
            level <= level_nxt;
    end

    // LED flop; gated by en so disabling blanks it on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            led <= 1'b0;
        else
            led <= en && (pwm_cnt < level);
    end

    assign busy = en && (level != target);

endmodule

// File: rtl/led_fader.sv
// PWM fade driver for the board LEDs: shared PWM and fade-tick
// counters feeding one ramping channel per LED.
module led_fader #(
    parameter int N_LEDS   = led_pkg::N_LEDS,
    parameter int PWM_BITS = led_pkg::PWM_BITS,
    parameter int FADE_DIV = led_pkg::FADE_DIV,
    parameter int STEP     = led_pkg::STEP
) (
    input  logic                CLOCK_27,
    input  logic                RST_N,
    input  logic [N_LEDS-1:0]   PATTERN,
    input  logic [PWM_BITS-1:0] MAX_LEVEL,
    input  logic                EN,
    output logic [N_LEDS-1:0]   LED,
    output logic                BUSY
);

    import led_pkg::*;

    localparam int TW = $clog2(FADE_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(FADE_DIV - 1);

    level_t              unused_level_t;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [TW-1:0]       tick_cnt;
    logic                tick;
    logic [N_LEDS-1:0]   busy_vec;

    assign unused_level_t = '0;
    assign tick = EN && (tick_cnt == TICK_LAST);

    // Free-running PWM phase, independent of EN.
    always_ff @(posedge CLOCK_27 or negedge RST_N) begin
        if (!RST_N)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + 1'b1;
    end

    // Fade divider: held at zero while disabled, wraps on tick.
    always_ff @(posedge CLOCK_27 or negedge RST_N) begin
        if (!RST_N)
            tick_cnt <= '0;
        else if (!EN || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS (PWM_BITS),
            .STEP     (STEP)
        ) u_ch (
            .clk       (CLOCK_27),
            .rst_n     (RST_N),
            .en        (EN),
            .tick      (tick),
            .on        (PATTERN[i]),
            .max_level (MAX_LEVEL),
            .pwm_cnt   (pwm_cnt),
            .led       (LED[i]),
            .busy      (busy_vec[i])
        );
    end

    assign BUSY = |busy_vec;

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader with a short fade divider
// and a large step so every fade completes in a few ticks.
module tb_led_fader;

    localparam int N  = 8;
    localparam int PB = 8;
    localparam int FD = 4;
    localparam int ST = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  pattern;
    logic [PB-1:0] max_level;
    logic          en;
    logic [N-1:0]  led;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    int          m_lvl [N];
    int          m_phase;
    int          m_ecnt;
    int          m_ticks = 0;
    logic [N-1:0] m_led;

    led_fader #(
        .N_LEDS   (N),
        .PWM_BITS (PB),
        .FADE_DIV (FD),
        .STEP     (ST)
    ) dut (
        .CLOCK_27  (clk),
        .RST_N     (rst_n),
        .PATTERN   (pattern),
        .MAX_LEVEL (max_level),
        .EN        (en),
        .LED       (led),
        .BUSY      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: every FD-th enabled cycle is a fade tick.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m_lvl[i] = 0;
            m_phase = 0;
            m_ecnt  = 0;
            m_led   = '0;
        end else begin
            for (int i = 0; i < N; i++)
                m_led[i] = en && (m_phase < m_lvl[i]);
            m_phase = (m_phase + 1) % 256;
            if (!en) begin
                m_ecnt = 0;
                for (int i = 0; i < N; i++) m_lvl[i] = 0;
            end else begin
                m_ecnt++;
                if (m_ecnt == FD) begin
                    m_ecnt = 0;
                    m_ticks++;
                    for (int i = 0; i < N; i++) begin
                        int t;
                        t = pattern[i] ? int'(max_level) : 0;
                        if (m_lvl[i] < t)
                            m_lvl[i] = (m_lvl[i] + ST > t) ? t : m_lvl[i] + ST;
                        else if (m_lvl[i] > t)
                            m_lvl[i] = (m_lvl[i] - ST < t) ? t : m_lvl[i] - ST;
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        logic eb;
        eb = 1'b0;
        for (int i = 0; i < N; i++)
            if (m_lvl[i] != (pattern[i] ? int'(max_level) : 0)) eb = 1'b1;
        eb = eb && en;
        check("led_cycle", 32'(led), 32'(m_led));
        check("busy_cycle", 32'(busy), 32'(eb));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic next_tick();
        int t0;
        int k;
        t0 = m_ticks;
        k = 0;
        while (m_ticks == t0 && k < 20) begin
            step();
            k++;
        end
        if (m_ticks == t0) check("tick_timeout", 32'(k), 32'(0));
    endtask

    task automatic duty(output int c0, output int pop);
        c0 = 0;
        pop = 0;
        repeat (256) begin
            @(negedge clk);
            c0 += int'(led[0]);
            pop += $countones(led);
        end
        #1;
    endtask

    initial begin
        int c0, pop;
        rst_n = 1'b0;
        en = 1'b1;
        pattern = '0;
        max_level = 8'd255;
        repeat (3) step();
        rst_n = 1'b1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_led", 32'(led), 32'd0);

        // Reset mid-fade
        pattern = 8'h01;
        next_tick();
        next_tick();
        check("pre_rst_lvl", 32'(m_lvl[0]), 32'd128);
        rst_n = 1'b0;
        pattern = '0;
        #1;
        check("async_led", 32'(led), 32'd0);
        step();
        check("rst_hold_led", 32'(led), 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_lvl", 32'(m_lvl[0]), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Rise 0 -> 255 on channel 0
        pattern = 8'h01;
        next_tick();
        check("up1", 32'(m_lvl[0]), 32'd64);
        check("up1_busy", 32'(busy), 32'd1);
        next_tick();
        check("up2", 32'(m_lvl[0]), 32'd128);
        next_tick();
        check("up3", 32'(m_lvl[0]), 32'd192);
        check("up3_busy", 32'(busy), 32'd1);
        next_tick();
        check("up4", 32'(m_lvl[0]), 32'd255);
        check("up4_busy", 32'(busy), 32'd0);
        step();
        duty(c0, pop);
        check("duty255", 32'(c0), 32'd255);
        check("duty255_others", 32'(pop - c0), 32'd0);

        // Fall 255 -> 0
        pattern = 8'h00;
        next_tick();
        check("dn1", 32'(m_lvl[0]), 32'd191);
        next_tick();
        check("dn2", 32'(m_lvl[0]), 32'd127);
        next_tick();
        check("dn3", 32'(m_lvl[0]), 32'd63);
        next_tick();
        check("dn4", 32'(m_lvl[0]), 32'd0);
        check("dn4_busy", 32'(busy), 32'd0);

        // Ceiling 128, steady duty
        max_level = 8'd128;
        pattern = 8'h01;
        next_tick();
        next_tick();
        check("cap128", 32'(m_lvl[0]), 32'd128);
        step();
        duty(c0, pop);
        check("duty128", 32'(c0), 32'd128);

        // All on with ceiling 100 (starts from ch0 = 128)
        pattern = '0;
        next_tick();
        next_tick();
        check("clr_ch0", 32'(m_lvl[0]), 32'd0);
        max_level = 8'd100;
        pattern = 8'hFF;
        next_tick();
        check("m100_a", 32'(m_lvl[3]), 32'd64);
        next_tick();
        check("m100_b", 32'(m_lvl[7]), 32'd100);
        check("m100_busy", 32'(busy), 32'd0);
        step();
        duty(c0, pop);
        check("duty100", 32'(c0), 32'd100);
        check("duty100_all", 32'(pop), 32'd800);

        // Reversal mid-fade
        pattern = '0;
        next_tick();
        check("rv_pre_a", 32'(m_lvl[0]), 32'd36);
        next_tick();
        max_level = 8'd255;
        pattern = 8'h01;
        next_tick();
        next_tick();
        check("rv_128", 32'(m_lvl[0]), 32'd128);
        pattern = 8'h00;
        next_tick();
        check("rv_64", 32'(m_lvl[0]), 32'd64);
        next_tick();
        check("rv_0", 32'(m_lvl[0]), 32'd0);

        // Disable at 192, then re-enable
        pattern = 8'hFF;
        next_tick();
        next_tick();
        next_tick();
        check("en_pre", 32'(m_lvl[5]), 32'd192);
        en = 1'b0;
        step();
        @(negedge clk);
        check("dis_led", 32'(led), 32'd0);
        check("dis_busy", 32'(busy), 32'd0);
        step();
        pattern = 8'h80;
        en = 1'b1;
        repeat (3) step();
        check("en_3clk", 32'(m_lvl[7]), 32'd0);
        step();
        check("en_4clk", 32'(m_lvl[7]), 32'd64);
        check("en_4clk_busy", 32'(busy), 32'd1);
        repeat (300) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
